// File: rtl/timer_sequencer_if.sv
// rtl/timer_sequencer_if.sv - button/tick inputs and display outputs of the timer sequencer
interface timer_sequencer_if #(
    parameter int BCD_COUNTER_BITS = 16
);
    logic                        tick;
    logic                        btn_start;
    logic                        btn_reset;
    logic                        btn_set;
    logic                        btn_min;
    logic                        btn_sec;
    logic [BCD_COUNTER_BITS-1:0] q;
    logic                        is_pause;
    logic                        is_restart;
    logic                        is_setting;
    logic                        done;

    modport master (
        output tick, btn_start, btn_reset, btn_set, btn_min, btn_sec,
        input  q, is_pause, is_restart, is_setting, done
    );

    modport slave (
        input  tick, btn_start, btn_reset, btn_set, btn_min, btn_sec,
        output q, is_pause, is_restart, is_setting, done
    );
endinterface

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - MM:SS BCD countdown sequencer (IDLE/SET/RUN/PAUSE/DONE)
module timer_sequencer #(
    parameter logic [15:0] PRESET_DEFAULT = 16'h0100
) (
    input  logic               clk,
    input  logic               rst_n,
    timer_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [15:0] q_r, q_next;
    logic [15:0] preset_r, preset_next;
    logic        done_r, done_next;

    // Two-digit BCD field increment, 59 wraps to 00 with no carry out.
    function automatic logic [7:0] inc60(input logic [7:0] f);
        if (f[3:0] == 4'd9) begin
            return (f[7:4] == 4'd5) ? 8'h00 : {f[7:4] + 4'd1, 4'd0};
        end
        return {f[7:4], f[3:0] + 4'd1};
    endfunction

    // One-second BCD decrement; seconds 00 borrows a minute and becomes 59.
    // 00:00 is left untouched so the count can never underflow.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else if (v[7:4] != 4'd0) begin
            r[7:4] = v[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else if (v[15:8] != 8'h00) begin
            r[7:0] = 8'h59;
            if (v[11:8] != 4'd0) begin
                r[11:8] = v[11:8] - 4'd1;
            end else begin
                r[15:12] = v[15:12] - 4'd1;
                r[11:8]  = 4'd9;
            end
        end
        return r;
    endfunction

    // State, count, preset and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            q_r      <= PRESET_DEFAULT;
            preset_r <= PRESET_DEFAULT;
            done_r   <= 1'b0;
        end else begin
            state    <= state_next;
            q_r      <= q_next;
            preset_r <= preset_next;
            done_r   <= done_next;
        end
    end

    // Next state and datapath: reset > set > start > tick, one event per cycle.
    always_comb begin
        state_next  = state;
        q_next      = q_r;
        preset_next = preset_r;
        case (state)
            ST_IDLE: begin
                if (bus.btn_reset) begin
                    q_next = preset_r;
                end else if (bus.btn_set) begin
                    state_next = ST_SET;
                end else if (bus.btn_start) begin
                    state_next = (q_r != 16'h0000) ? ST_RUN : ST_DONE;
                end
            end
            ST_SET: begin
                // Minute and second buttons are independent and may coincide.
                if (bus.btn_min) preset_next[15:8] = inc60(preset_r[15:8]);
                if (bus.btn_sec) preset_next[7:0]  = inc60(preset_r[7:0]);
                q_next = preset_next;
                if (bus.btn_set) state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.btn_reset) begin
                    state_next = ST_IDLE;
                    q_next     = preset_r;
                end else if (bus.btn_start) begin
                    state_next = ST_PAUSE;
                end else if (bus.tick) begin
                    q_next = dec_bcd(q_r);
                    if (q_r == 16'h0001) state_next = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (bus.btn_reset) begin
                    state_next = ST_IDLE;
                    q_next     = preset_r;
                end else if (bus.btn_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.btn_reset) begin
                    state_next = ST_IDLE;
                    q_next     = preset_r;
                end else begin
                    q_next = 16'h0000;
                end
            end
            default: begin
                state_next = ST_IDLE;
                q_next     = preset_r;
            end
        endcase
        done_next = (state_next == ST_DONE) && (state != ST_DONE);
    end

    // Status flags decoded from the state register only.
    always_comb begin
        bus.is_pause   = (state == ST_IDLE) || (state == ST_PAUSE);
        bus.is_restart = (state == ST_RUN) || (state == ST_PAUSE) || (state == ST_DONE);
        bus.is_setting = (state == ST_SET);
        bus.q          = q_r;
        bus.done       = done_r;
    end
endmodule
